// File: rtl/fp_int_mul_serial_param_pkg.sv
// Shared definitions for the bit-serial FP16 x INTn multiplier: FP16 field layout,
// weight encodings, FSM states and width helpers.
package fp_int_mul_serial_param_pkg;

  localparam int FP_EXP_LSB = 10;
  localparam int FP_EXP_W   = 5;
  localparam int FP_FRAC_W  = 10;

  localparam logic MODE_SM = 1'b0;
  localparam logic MODE_TC = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACC  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // 11-bit significand times a (W_MAX-1)-bit magnitude
  function automatic int mant_w(input int w_max);
    return 11 + w_max - 1;
  endfunction

  function automatic logic [3:0] clamp_prec(input logic [3:0] p, input logic [3:0] p_max);
    if (p == 4'd0) begin
      return 4'd1;
    end else if (p > p_max) begin
      return p_max;
    end else begin
      return p;
    end
  endfunction

endpackage

// File: rtl/fp_int_mul_serial_param_if.sv
// Configuration, input-beat and product handshake bundle of the serial multiplier.
interface fp_int_mul_serial_param_if
  import fp_int_mul_serial_param_pkg::*;
#(
  parameter int ACT_WIDTH = 16,
  parameter int W_MAX     = 8
) ();

  localparam int MANT_W = mant_w(W_MAX);

  logic                 set;
  logic [3:0]           precision;
  logic                 mode;
  logic                 flush;
  logic                 in_valid;
  logic                 in_ready;
  logic [ACT_WIDTH-1:0] act;
  logic                 w;
  logic                 out_valid;
  logic                 out_ready;
  logic                 sign_out;
  logic [4:0]           exp_out;
  logic [MANT_W-1:0]    mantissa_out;

  modport master (
    output set, precision, mode, flush, in_valid, act, w, out_ready,
    input  in_ready, out_valid, sign_out, exp_out, mantissa_out
  );

  modport slave (
    input  set, precision, mode, flush, in_valid, act, w, out_ready,
    output in_ready, out_valid, sign_out, exp_out, mantissa_out
  );

endinterface

// File: rtl/fp_int_mul_serial_param_shift_acc.sv
// Signed Horner shift-add accumulator: one weight bit per step, MSB first.
// acc_next_o exposes the value that will be registered at the coming edge.
module fp_int_mul_serial_param_shift_acc
  import fp_int_mul_serial_param_pkg::*;
#(
  parameter int MANT_W = 18
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     clear_i,
  input  logic                     step_i,
  input  logic                     first_i,
  input  logic                     mode_i,
  input  logic                     w_i,
  input  logic [10:0]              mant_i,
  output logic signed [MANT_W:0]   acc_next_o
);

  logic signed [MANT_W:0] acc_q, acc_d, addend_s;

  // next accumulator value; the first beat is the sign bit (SM) or the -2^(P-1) weight (TC)
  always_comb begin
    addend_s = w_i ? signed'({{(MANT_W-10){1'b0}}, mant_i}) : {(MANT_W+1){1'b0}};
    acc_d    = acc_q;
    if (clear_i) begin
      acc_d = {(MANT_W+1){1'b0}};
    end else if (step_i) begin
      if (first_i) begin
        acc_d = (mode_i == MODE_SM) ? {(MANT_W+1){1'b0}} : -addend_s;
      end else begin
        acc_d = (acc_q <<< 1) + addend_s;
      end
    end else begin
      acc_d = acc_q;
    end
  end

  // accumulator register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      acc_q <= {(MANT_W+1){1'b0}};
    end else begin
      acc_q <= acc_d;
    end
  end

  assign acc_next_o = acc_d;

endmodule

// File: rtl/fp_int_mul_serial_param.sv
// Bit-serial FP16 x INTn multiplier: FSM, beat counter, handshakes and the
// registered sign/exponent/|mantissa| product stage.
module fp_int_mul_serial_param
  import fp_int_mul_serial_param_pkg::*;
#(
  parameter int ACT_WIDTH = 16,
  parameter int W_MAX     = 8
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  fp_int_mul_serial_param_if.slave bus
);

  localparam int         MANT_W   = mant_w(W_MAX);
  localparam logic [3:0] PREC_MAX = 4'(W_MAX);

  state_e              state_q, state_d;
  logic [3:0]          cnt_q, cnt_d, prec_q, prec_d;
  logic                mode_q, mode_d, asign_q, asign_d, w0_q, w0_d;
  logic [4:0]          exp_q, exp_d, eo_q, eo_d;
  logic [10:0]         mant_q, mant_d, mant_cur_s;
  logic                ov_q, ov_d, sign_q, sign_d;
  logic [MANT_W-1:0]   mo_q, mo_d, mag_s;
  logic                in_ready_s, accept_s, first_s, last_s, neg_s, res_sign_s;
  logic                asign_cur_s, w0_cur_s;
  logic [4:0]          exp_cur_s;
  logic signed [MANT_W:0] acc_next_s;

  // handshake qualification and the operand view of the current beat
  always_comb begin
    in_ready_s  = (state_q != ST_DONE) | bus.out_ready;
    accept_s    = bus.in_valid & in_ready_s & ~bus.flush;
    first_s     = accept_s & (state_q != ST_ACC);
    last_s      = (cnt_q == (prec_q - 4'd1));
    asign_cur_s = first_s ? bus.act[ACT_WIDTH-1] : asign_q;
    exp_cur_s   = first_s ? bus.act[FP_EXP_LSB +: FP_EXP_W] : exp_q;
    mant_cur_s  = first_s ? {(bus.act[FP_EXP_LSB +: FP_EXP_W] != 5'd0), bus.act[FP_FRAC_W-1:0]}
                          : mant_q;
    w0_cur_s    = first_s ? bus.w : w0_q;
    neg_s       = acc_next_s[MANT_W];
    mag_s       = MANT_W'(neg_s ? -acc_next_s : acc_next_s);
    if (mag_s == {MANT_W{1'b0}}) begin
      res_sign_s = 1'b0;
    end else if (mode_q == MODE_TC) begin
      res_sign_s = asign_cur_s ^ neg_s;
    end else begin
      res_sign_s = asign_cur_s ^ w0_cur_s;
    end
  end

  fp_int_mul_serial_param_shift_acc #(.MANT_W(MANT_W)) u_acc (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .clear_i    (bus.flush),
    .step_i     (accept_s),
    .first_i    (first_s),
    .mode_i     (mode_q),
    .w_i        (bus.w),
    .mant_i     (mant_cur_s),
    .acc_next_o (acc_next_s)
  );

  // next-state logic; a DONE hand-off and a new first beat may happen in the same cycle
  always_comb begin
    state_d = state_q;  cnt_d  = cnt_q;   prec_d = prec_q;  mode_d = mode_q;
    asign_d = asign_q;  exp_d  = exp_q;   mant_d = mant_q;  w0_d   = w0_q;
    ov_d    = ov_q;     sign_d = sign_q;  eo_d   = eo_q;    mo_d   = mo_q;
    if (bus.flush) begin
      state_d = ST_IDLE;
      cnt_d   = 4'd0;
      ov_d    = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (bus.set) begin
            prec_d = clamp_prec(bus.precision, PREC_MAX);
            mode_d = bus.mode;
          end else begin
            prec_d = prec_q;
          end
        end
        ST_ACC: begin
          state_d = ST_ACC;
        end
        ST_DONE: begin
          if (bus.out_ready) begin
            ov_d    = 1'b0;
            state_d = ST_IDLE;
          end else begin
            ov_d = 1'b1;
          end
        end
        default: state_d = ST_IDLE;
      endcase
      if (accept_s) begin
        asign_d = asign_cur_s;
        exp_d   = exp_cur_s;
        mant_d  = mant_cur_s;
        w0_d    = w0_cur_s;
        if (last_s) begin
          cnt_d   = 4'd0;
          state_d = ST_DONE;
          ov_d    = 1'b1;
          sign_d  = res_sign_s;
          eo_d    = exp_cur_s;
          mo_d    = mag_s;
        end else begin
          cnt_d   = cnt_q + 4'd1;
          state_d = ST_ACC;
        end
      end else begin
        cnt_d = cnt_d;
      end
    end
  end

  // state, operand latches and output registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;  cnt_q  <= 4'd0;  prec_q <= 4'd1;   mode_q <= 1'b0;
      asign_q <= 1'b0;     exp_q  <= 5'd0;  mant_q <= 11'd0;  w0_q   <= 1'b0;
      ov_q    <= 1'b0;     sign_q <= 1'b0;  eo_q   <= 5'd0;   mo_q   <= {MANT_W{1'b0}};
    end else begin
      state_q <= state_d;  cnt_q  <= cnt_d;   prec_q <= prec_d;  mode_q <= mode_d;
      asign_q <= asign_d;  exp_q  <= exp_d;   mant_q <= mant_d;  w0_q   <= w0_d;
      ov_q    <= ov_d;     sign_q <= sign_d;  eo_q   <= eo_d;    mo_q   <= mo_d;
    end
  end

  assign bus.in_ready     = in_ready_s;
  assign bus.out_valid    = ov_q;
  assign bus.sign_out     = sign_q;
  assign bus.exp_out      = eo_q;
  assign bus.mantissa_out = mo_q;

endmodule

// File: tb/tb_fp_int_mul_serial_param.sv
// Self-checking bench for fp_int_mul_serial_param: directed vectors plus randomized
// transactions compared against an integer-arithmetic reference model.
module tb_fp_int_mul_serial_param;

  logic clk = 1'b0;
  logic rst_n;
  int   cmp_n = 0;
  int   err_n = 0;

  always #5 clk = ~clk;

  fp_int_mul_serial_param_if #(.ACT_WIDTH(16), .W_MAX(8)) bus ();

  fp_int_mul_serial_param #(.ACT_WIDTH(16), .W_MAX(8)) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus)
  );

  // Product of the FP16 significand and the integer weight, computed arithmetically.
  function automatic logic [24:0] model(input bit m, input int p, input logic [15:0] a, input int wv);
    int m11, val, prod, mag;
    bit s;
    m11 = ((a[14:10] != 5'd0) ? 1024 : 0) + int'(a[9:0]);
    if (m == 1'b0) begin
      val = wv & ((1 << (p - 1)) - 1);
      if (wv[p-1]) val = -val;
    end else begin
      val = wv;
      if (wv[p-1]) val = wv - (1 << p);
    end
    prod = m11 * val;
    mag  = (prod < 0) ? -prod : prod;
    s    = (mag == 0) ? 1'b0 : ((val < 0) ^ a[15]);
    return {1'b1, s, a[14:10], 18'(mag)};
  endfunction

  function automatic logic [24:0] observed();
    return {bus.out_valid, bus.sign_out, bus.exp_out, bus.mantissa_out};
  endfunction

  task automatic set_cfg(input logic [3:0] p, input bit m);
    bus.in_valid = 1'b0;
    @(posedge clk); #1;
    bus.set = 1'b1; bus.precision = p; bus.mode = m;
    @(posedge clk); #1;
    bus.set = 1'b0;
  endtask

  // Drives p beats MSB first; returns at the sample point after the last beat's edge.
  task automatic send_txn(input logic [15:0] a, input int wv, input int p, input int stall_at,
                          input int set_at, input logic [3:0] set_prec, output bit early_ov);
    early_ov = 1'b0;
    for (int i = 0; i < p; i++) begin
      if (i == stall_at) begin
        bus.in_valid = 1'b0;
        repeat (3) begin
          @(posedge clk); #1;
          if (bus.out_valid) early_ov = 1'b1;
        end
      end
      bus.in_valid  = 1'b1;
      bus.w         = wv[p-1-i];
      bus.act       = (i == 0) ? a : 16'($urandom);
      bus.set       = (i == set_at);
      bus.precision = set_prec;
      @(posedge clk); #1;
      if (i < p - 1 && bus.out_valid) early_ov = 1'b1;
    end
    bus.in_valid = 1'b0;
    bus.set      = 1'b0;
  endtask

  task automatic test_reset();
    bus.set = 1'b0; bus.precision = 4'd0; bus.mode = 1'b0; bus.flush = 1'b0;
    bus.in_valid = 1'b0; bus.act = 16'd0; bus.w = 1'b0; bus.out_ready = 1'b1;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    cmp_n++;
    if (observed() !== 25'd0) begin
      err_n++; $display("FAIL reset_outputs got %h want %h", observed(), 25'd0);
    end
    cmp_n++;
    if (bus.in_ready !== 1'b1) begin
      err_n++; $display("FAIL reset_in_ready got %b want 1", bus.in_ready);
    end
  endtask

  task automatic test_directed();
    logic [15:0] acts [5] = '{16'h3C00, 16'hBC00, 16'hBC00, 16'h0001, 16'h0000};
    int          wvs  [5] = '{5, 13, 3, 128, 128};
    int          ps   [5] = '{4, 4, 4, 8, 8};
    bit          ms   [5] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    logic [24:0] want [5] = '{{1'b1, 1'b0, 5'd15, 18'd5120}, {1'b1, 1'b0, 5'd15, 18'd3072},
                              {1'b1, 1'b1, 5'd15, 18'd3072}, {1'b1, 1'b1, 5'd0, 18'd128},
                              {1'b1, 1'b0, 5'd0, 18'd0}};
    bit early;
    for (int k = 0; k < 5; k++) begin
      set_cfg(4'(ps[k]), ms[k]);
      send_txn(acts[k], wvs[k], ps[k], -1, -1, 4'd0, early);
      cmp_n++;
      if (early !== 1'b0 || observed() !== want[k]) begin
        err_n++; $display("FAIL directed_%0d got early=%b ov/s/e/m=%h want early=0 %h", k, early, observed(), want[k]);
      end
    end
  endtask

  task automatic test_random();
    bit early, m;
    int p, wv, stall;
    logic [15:0] a;
    logic [24:0] want;
    for (int k = 0; k < 40; k++) begin
      m     = 1'($urandom_range(0, 1));
      p     = $urandom_range(1, 8);
      a     = 16'($urandom);
      wv    = $urandom_range(0, (1 << p) - 1);
      stall = ($urandom_range(0, 3) == 0) ? $urandom_range(0, p - 1) : -1;
      set_cfg(4'(p), m);
      send_txn(a, wv, p, stall, -1, 4'd0, early);
      want = model(m, p, a, wv);
      cmp_n++;
      if (early !== 1'b0 || observed() !== want) begin
        err_n++; $display("FAIL random_%0d mode=%0d p=%0d act=%h w=%0d got early=%b %h want %h", k, m, p, a, wv, early, observed(), want);
      end
    end
  endtask

  task automatic test_stall();
    bit early;
    logic [15:0] a = 16'($urandom);
    int wv = $urandom_range(0, 63);
    logic [24:0] want = model(1'b1, 6, a, wv);
    set_cfg(4'd6, 1'b1);
    bus.out_ready = 1'b0;
    send_txn(a, wv, 6, 2, -1, 4'd0, early);
    cmp_n++;
    if (early !== 1'b0 || observed() !== want) begin
      err_n++; $display("FAIL stall_result got early=%b %h want %h", early, observed(), want);
    end
    bus.in_valid = 1'b1; bus.w = 1'b1; bus.act = 16'($urandom);
    for (int c = 0; c < 5; c++) begin
      cmp_n++;
      if (bus.in_ready !== 1'b0 || observed() !== want) begin
        err_n++; $display("FAIL stall_hold_%0d got in_ready=%b %h want 0 %h", c, bus.in_ready, observed(), want);
      end
      @(posedge clk); #1;
    end
    bus.in_valid = 1'b0; bus.out_ready = 1'b1;
    @(posedge clk); #1;
    cmp_n++;
    if (bus.out_valid !== 1'b0) begin
      err_n++; $display("FAIL stall_release got out_valid=%b want 0", bus.out_valid);
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] acts [2];
    int          wvs  [2];
    logic [24:0] want;
    set_cfg(4'd4, 1'b0);
    for (int t = 0; t < 2; t++) begin
      acts[t] = 16'($urandom); wvs[t] = $urandom_range(0, 15);
    end
    for (int i = 0; i < 8; i++) begin
      bus.in_valid = 1'b1;
      bus.w        = wvs[i/4][3-(i%4)];
      bus.act      = ((i % 4) == 0) ? acts[i/4] : 16'($urandom);
      cmp_n++;
      if (bus.in_ready !== 1'b1) begin
        err_n++; $display("FAIL b2b_ready_%0d got %b want 1", i, bus.in_ready);
      end
      @(posedge clk); #1;
      if (i == 3 || i == 7) begin
        want = model(1'b0, 4, acts[i/4], wvs[i/4]);
        cmp_n++;
        if (observed() !== want) begin
          err_n++; $display("FAIL b2b_result_%0d got %h want %h", i / 4, observed(), want);
        end
      end else if (i == 4) begin
        cmp_n++;
        if (bus.out_valid !== 1'b0) begin
          err_n++; $display("FAIL b2b_handoff got out_valid=%b want 0", bus.out_valid);
        end
      end
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic test_flush();
    bit early, seen = 1'b0;
    logic [15:0] a = 16'($urandom);
    int wv = $urandom_range(0, 15);
    set_cfg(4'd4, 1'b1);
    for (int i = 0; i < 2; i++) begin
      bus.in_valid = 1'b1; bus.w = 1'b1; bus.act = 16'hFFFF;
      @(posedge clk); #1;
    end
    bus.flush = 1'b1;
    @(posedge clk); #1;
    bus.flush = 1'b0; bus.in_valid = 1'b0;
    repeat (6) begin
      if (bus.out_valid) seen = 1'b1;
      @(posedge clk); #1;
    end
    cmp_n++;
    if (seen !== 1'b0) begin
      err_n++; $display("FAIL flush_no_output got out_valid seen=%b want 0", seen);
    end
    send_txn(a, wv, 4, -1, -1, 4'd0, early);
    cmp_n++;
    if (early !== 1'b0 || observed() !== model(1'b1, 4, a, wv)) begin
      err_n++; $display("FAIL flush_next got early=%b %h want %h", early, observed(), model(1'b1, 4, a, wv));
    end
  endtask

  task automatic test_set();
    bit early;
    logic [15:0] a;
    int wv;
    set_cfg(4'd0, 1'b0);
    a = 16'($urandom);
    send_txn(a, 1, 1, -1, -1, 4'd0, early);
    cmp_n++;
    if (observed() !== model(1'b0, 1, a, 1)) begin
      err_n++; $display("FAIL set_prec0 got %h want %h", observed(), model(1'b0, 1, a, 1));
    end
    set_cfg(4'd12, 1'b1);
    a = 16'($urandom); wv = $urandom_range(0, 255);
    send_txn(a, wv, 8, -1, -1, 4'd0, early);
    cmp_n++;
    if (early !== 1'b0 || observed() !== model(1'b1, 8, a, wv)) begin
      err_n++; $display("FAIL set_prec12 got early=%b %h want %h", early, observed(), model(1'b1, 8, a, wv));
    end
    set_cfg(4'd4, 1'b0);
    for (int k = 0; k < 2; k++) begin
      a = 16'($urandom); wv = $urandom_range(0, 15);
      send_txn(a, wv, 4, -1, (k == 0) ? 1 : -1, 4'd2, early);
      cmp_n++;
      if (early !== 1'b0 || observed() !== model(1'b0, 4, a, wv)) begin
        err_n++; $display("FAIL set_in_acc_%0d got early=%b %h want %h", k, early, observed(), model(1'b0, 4, a, wv));
      end
    end
  endtask

  task automatic test_async_reset();
    bit early;
    logic [15:0] a = 16'($urandom);
    set_cfg(4'd5, 1'b1);
    for (int i = 0; i < 2; i++) begin
      bus.in_valid = 1'b1; bus.w = 1'b1; bus.act = a;
      @(posedge clk); #1;
    end
    rst_n = 1'b0;
    #2;
    cmp_n++;
    if (observed() !== 25'd0 || bus.in_ready !== 1'b1) begin
      err_n++; $display("FAIL async_reset got %h in_ready=%b want 0 1", observed(), bus.in_ready);
    end
    bus.in_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    send_txn(a, 1, 1, -1, -1, 4'd0, early);
    cmp_n++;
    if (observed() !== model(1'b0, 1, a, 1)) begin
      err_n++; $display("FAIL async_reset_cfg got %h want %h", observed(), model(1'b0, 1, a, 1));
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_stall();
    test_back_to_back();
    test_flush();
    test_set();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_n, err_n);
    $finish;
  end

endmodule
